// File: rtl/spawn_scheduler.sv
// rtl/spawn_scheduler.sv - falling-object spawn scheduler over a pool of object slots
// Optional SPAWN_SPEEDUP_EN shortens the spawn interval as spawns accumulate.
module spawn_scheduler #(
  parameter int NUM_SLOTS     = 4,
  parameter int INTERVAL      = 1000,
  parameter int X_MAX         = 1023,
  parameter int MIN_INTERVAL  = 100,
  parameter int SPEEDUP_EVERY = 8,
  parameter int SPEEDUP_STEP  = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [10:0]          random_number,
  input  logic [NUM_SLOTS-1:0] slot_done,
  output logic [NUM_SLOTS-1:0] spawn_valid,
  output logic [10:0]          spawn_x,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [15:0]          spawn_count
);

  localparam int TW = $clog2(INTERVAL + 1);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_PICK,
    S_SPAWN
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [10:0]          x_q, x_d;
  logic [NUM_SLOTS-1:0] spawn_valid_q, spawn_valid_d;
  logic [10:0]          spawn_x_q, spawn_x_d;
  logic [NUM_SLOTS-1:0] slot_busy_q, slot_busy_d;
  logic [15:0]          spawn_count_q, spawn_count_d;
  logic [TW-1:0]        cur_interval;

  logic [SW-1:0]        free_idx;
  logic                 free_found;
  logic [10:0]          r_off;
  logic [10:0]          x_map;

  // Lowest-index free slot wins; scan from the top so the last hit is the lowest.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy_q[i]) begin
        free_idx   = SW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    r_off = random_number - 11'(X_MAX + 1);
    if (random_number <= 11'(X_MAX)) begin
      x_map = random_number;
    end else if (r_off > 11'(X_MAX)) begin
      x_map = 11'(X_MAX);
    end else begin
      x_map = r_off;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    slot_d        = slot_q;
    x_d           = x_q;
    spawn_valid_d = '0;
    spawn_x_d     = '0;
    slot_busy_d   = slot_busy_q & ~slot_done;
    spawn_count_d = spawn_count_q;
    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COUNT;
          timer_d = '0;
        end
        S_COUNT: begin
          if (timer_q == cur_interval - TW'(1)) begin
            state_d = S_PICK;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_PICK: begin
          if (free_found) begin
            slot_d  = free_idx;
            x_d     = x_map;
            state_d = S_SPAWN;
          end
        end
        S_SPAWN: begin
          spawn_valid_d = NUM_SLOTS'(1) << slot_q;
          spawn_x_d     = x_q;
          slot_busy_d   = (slot_busy_q & ~slot_done) | (NUM_SLOTS'(1) << slot_q);
          spawn_count_d = spawn_count_q + 16'd1;
          state_d       = S_COUNT;
          timer_d       = '0;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      slot_q        <= '0;
      x_q           <= '0;
      spawn_valid_q <= '0;
      spawn_x_q     <= '0;
      slot_busy_q   <= '0;
      spawn_count_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      slot_q        <= slot_d;
      x_q           <= x_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_x_q     <= spawn_x_d;
      slot_busy_q   <= slot_busy_d;
      spawn_count_q <= spawn_count_d;
    end
  end

`ifdef SPAWN_SPEEDUP_EN
  localparam int EW = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

  logic [TW-1:0] cur_interval_q, cur_interval_d;
  logic [EW-1:0] speedup_cnt_q, speedup_cnt_d;
  logic [31:0]   cur_ext;

  // The reduced interval is committed on the spawn edge, so the COUNT that follows uses it.
  always_comb begin
    cur_interval_d = cur_interval_q;
    speedup_cnt_d  = speedup_cnt_q;
    cur_ext        = 32'(cur_interval_q);
    if (spawn_valid_d != '0) begin
      if (speedup_cnt_q == EW'(SPEEDUP_EVERY - 1)) begin
        speedup_cnt_d = '0;
        if (cur_ext >= 32'(MIN_INTERVAL + SPEEDUP_STEP)) begin
          cur_interval_d = TW'(cur_ext - 32'(SPEEDUP_STEP));
        end else begin
          cur_interval_d = TW'(MIN_INTERVAL);
        end
      end else begin
        speedup_cnt_d = speedup_cnt_q + EW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_interval_q <= TW'(INTERVAL);
      speedup_cnt_q  <= '0;
    end else begin
      cur_interval_q <= cur_interval_d;
      speedup_cnt_q  <= speedup_cnt_d;
    end
  end

  assign cur_interval = cur_interval_q;
`else
  logic unused_speedup_cfg;

  assign cur_interval       = TW'(INTERVAL);
  assign unused_speedup_cfg = (MIN_INTERVAL + SPEEDUP_EVERY + SPEEDUP_STEP) != 0;
`endif

  assign spawn_valid = spawn_valid_q;
  assign spawn_x     = spawn_x_q;
  assign slot_busy   = slot_busy_q;
  assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb/tb_spawn_scheduler.sv - self-checking bench for spawn_scheduler
// Event-time reference model plus directed literal checks; SPAWN_SPEEDUP_EN selects the speedup scenario.
module tb_spawn_scheduler;

`ifdef SPAWN_SPEEDUP_EN
  localparam int INTERVAL = 20;
`else
  localparam int INTERVAL = 8;
`endif
  localparam int NUM_SLOTS     = 4;
  localparam int X_MAX         = 1023;
  localparam int MIN_INTERVAL  = 12;
  localparam int SPEEDUP_EVERY = 2;
  localparam int SPEEDUP_STEP  = 5;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [10:0] random_number;
  logic [3:0]  slot_done;
  logic [3:0]  spawn_valid;
  logic [10:0] spawn_x;
  logic [3:0]  slot_busy;
  logic [15:0] spawn_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  spawn_scheduler #(
    .NUM_SLOTS    (NUM_SLOTS),
    .INTERVAL     (INTERVAL),
    .X_MAX        (X_MAX),
    .MIN_INTERVAL (MIN_INTERVAL),
    .SPEEDUP_EVERY(SPEEDUP_EVERY),
    .SPEEDUP_STEP (SPEEDUP_STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .random_number(random_number),
    .slot_done    (slot_done),
    .spawn_valid  (spawn_valid),
    .spawn_x      (spawn_x),
    .slot_busy    (slot_busy),
    .spawn_count  (spawn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [10:0] x_of(input int r);
    int v;
    if (r <= X_MAX) v = r;
    else begin
      v = r - (X_MAX + 1);
      if (v > X_MAX) v = X_MAX;
    end
    return 11'(v);
  endfunction

  // Reference model: tracks the edge numbers at which a pick decision and a spawn are due.
  int          cyc;
  bit          m_running;
  int          m_decide;
  int          m_spawn_at;
  int          m_cur;
  int          m_spawns;
  int          m_slot;
  logic [3:0]  m_busy;
  logic [3:0]  m_valid;
  logic [10:0] m_x;
  logic [10:0] m_x_pending;
  logic [15:0] m_count;

  always @(posedge clk or negedge rst) begin
    logic [3:0] nb;
    if (!rst) begin
      cyc        = 0;
      m_running  = 0;
      m_decide   = -1;
      m_spawn_at = -1;
      m_cur      = INTERVAL;
      m_spawns   = 0;
      m_slot     = 0;
      m_busy     = '0;
      m_valid    = '0;
      m_x        = '0;
      m_x_pending = '0;
      m_count    = '0;
    end else begin
      cyc++;
      m_valid = '0;
      m_x     = '0;
      nb      = m_busy & ~slot_done;
      if (!enable) begin
        m_running  = 0;
        m_decide   = -1;
        m_spawn_at = -1;
      end else if (!m_running) begin
        m_running = 1;
        m_decide  = cyc + m_cur + 1;
      end else if (cyc == m_spawn_at) begin
        m_valid = 4'(1 << m_slot);
        m_x     = m_x_pending;
        nb      = nb | m_valid;
        m_count = m_count + 16'd1;
        m_spawns++;
`ifdef SPAWN_SPEEDUP_EN
        if (m_spawns % SPEEDUP_EVERY == 0) begin
          m_cur = m_cur - SPEEDUP_STEP;
          if (m_cur < MIN_INTERVAL) m_cur = MIN_INTERVAL;
        end
`endif
        m_spawn_at = -1;
        m_decide   = cyc + m_cur + 1;
      end else if (cyc == m_decide) begin
        if (m_busy != 4'hF) begin
          m_slot = 0;
          while (m_busy[m_slot]) m_slot++;
          m_x_pending = x_of(int'(random_number));
          m_spawn_at  = cyc + 1;
        end else begin
          m_decide = cyc + 1;
        end
      end
      m_busy = nb;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1)
      check("model_vs_dut", {spawn_valid, spawn_x, slot_busy, spawn_count},
            {m_valid, m_x, m_busy, m_count});
  end

  task automatic wait_spawn(input int max_cyc, output int at, output logic [3:0] v,
                            output logic [10:0] x);
    bit ok;
    ok = 0;
    at = -1;
    v  = '0;
    x  = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (spawn_valid != '0) begin
        ok = 1;
        at = cyc;
        v  = spawn_valid;
        x  = spawn_x;
        break;
      end
    end
    check("spawn_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int          prev;
    int          at;
    int          mark;
    bit          seen;
    logic [3:0]  v;
    logic [10:0] x;
    int          rns[4]    = '{500, 1500, 2047, 3};
    logic [10:0] exp_x[4]  = '{11'd500, 11'd476, 11'd1023, 11'd3};
    logic [3:0]  exp_v[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int          exp_p[7]  = '{22, 22, 17, 17, 14, 14, 14};

    rst           = 1'b0;
    enable        = 1'b0;
    slot_done     = '0;
    random_number = '0;
    repeat (5) @(negedge clk);
    check("reset_outputs", {spawn_valid, spawn_x, slot_busy, spawn_count}, 64'd0);
    rst  = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (spawn_valid != '0) seen = 1;
    end
    check("idle_no_spawn", 64'(seen), 64'd0);
    check("idle_outputs", {spawn_valid, spawn_x, slot_busy, spawn_count}, 64'd0);

`ifdef SPAWN_SPEEDUP_EN
    random_number = 11'd7;
    enable        = 1'b1;
    prev          = cyc + 1;
    for (int k = 0; k < 7; k++) begin
      wait_spawn(40, at, v, x);
      check($sformatf("speedup_period_%0d", k), 64'(at - prev), 64'(exp_p[k]));
      prev      = at;
      slot_done = v;
      @(negedge clk);
      slot_done = '0;
    end
    check("speedup_count", 64'(spawn_count), 64'd7);
`else
    enable = 1'b1;
    prev   = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      random_number = 11'(rns[k]);
      wait_spawn(INTERVAL + 6, at, v, x);
      check($sformatf("spawn_gap_%0d", k), 64'(at - prev), 64'(INTERVAL + 2));
      check($sformatf("spawn_onehot_%0d", k), 64'(v), 64'(exp_v[k]));
      check($sformatf("spawn_x_%0d", k), 64'(x), 64'(exp_x[k]));
      prev = at;
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (spawn_valid != '0) seen = 1;
    end
    check("stall_no_spawn", 64'(seen), 64'd0);
    check("stall_busy", 64'(slot_busy), 64'hF);
    check("stall_count", 64'(spawn_count), 64'd4);

    random_number = 11'd1024;
    slot_done     = 4'b0100;
    mark          = cyc;
    @(negedge clk);
    slot_done = '0;
    wait_spawn(4, at, v, x);
    check("release_latency", 64'(at - mark), 64'd3);
    check("release_slot", 64'(v), 64'b0100);
    check("release_x", 64'(x), 64'd0);
    check("release_busy", 64'(slot_busy), 64'hF);

    slot_done = 4'b0011;
    @(negedge clk);
    slot_done = '0;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("pause_busy_kept", 64'(slot_busy), 64'b1100);
    enable = 1'b1;
    mark   = cyc + 1;
    wait_spawn(INTERVAL + 6, at, v, x);
    check("resume_delay", 64'(at - mark), 64'(INTERVAL + 2));
    check("resume_slot", 64'(v), 64'b0001);
    check("resume_busy", 64'(slot_busy), 64'b1101);

    slot_done = 4'b0010;
    @(negedge clk);
    slot_done = '0;
    @(negedge clk);
    check("done_on_free_ignored", 64'(slot_busy), 64'b1101);
    wait_spawn(INTERVAL + 6, at, v, x);
    check("next_slot", 64'(v), 64'b0010);
    check("final_count", 64'(spawn_count), 64'd7);
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
